ram_port_arbiter: RTL



---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/rr_arbiter2.sv | 30 +++
 rtl/ram_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and port indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int PORT_INSTR = 0;
  localparam int PORT_DATA  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: combinational winner, registered last_grant.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic       winner,
  output logic       last_grant
);

  // A lone requester always wins; on a tie the port that did not win last time goes.
  always_comb begin
    winner = valid[1];
    if (valid == 2'b11) begin
      winner = ~last_grant;
    end
  end

  // Reset to the data port so the instruction port wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'(PORT_DATA);
    end else if (grant_en) begin
      last_grant <= winner;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM controller port between instruction fetch (port 0) and load/store (port 1).
// Handshake: a requester holds req_valid (and its fields) until a one-cycle req_ready pulse, then drops or changes it.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 28,
  parameter int DATA_SIZE      = 32,
  parameter int MASK_SIZE      = DATA_SIZE / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    p0_req_valid,
  input  logic                    p0_req_write,
  input  logic [ADDRESS_SIZE-1:0] p0_req_address,
  input  logic [MASK_SIZE-1:0]    p0_req_mask,
  input  logic [DATA_SIZE-1:0]    p0_req_wdata,
  output logic                    p0_req_ready,
  output logic                    p0_resp_valid,
  output logic [DATA_SIZE-1:0]    p0_resp_rdata,
  output logic                    p0_resp_error,
  input  logic                    p1_req_valid,
  input  logic                    p1_req_write,
  input  logic [ADDRESS_SIZE-1:0] p1_req_address,
  input  logic [MASK_SIZE-1:0]    p1_req_mask,
  input  logic [DATA_SIZE-1:0]    p1_req_wdata,
  output logic                    p1_req_ready,
  output logic                    p1_resp_valid,
  output logic [DATA_SIZE-1:0]    p1_resp_rdata,
  output logic                    p1_resp_error,
  output logic [ADDRESS_SIZE-1:0] ram_address,
  output logic [MASK_SIZE-1:0]    ram_mask,
  output logic                    ram_write_trigger,
  output logic                    ram_read_trigger,
  output logic [DATA_SIZE-1:0]    ram_write_value,
  input  logic [DATA_SIZE-1:0]    ram_read_value,
  input  logic                    ram_controller_ready,
  input  logic [3:0]              ram_error,
  output arb_state_t              dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t state, state_n;
  logic grant, complete, timeout;
  logic winner, last_grant;
  logic wr_q, seen_busy;
  logic [CW-1:0] wait_cnt, cnt_inc;
  logic [1:0] req_ready_q, resp_valid_q, error_q;
  logic [DATA_SIZE-1:0] rdata_q [2];

  logic                    win_write;
  logic [ADDRESS_SIZE-1:0] win_address;
  logic [MASK_SIZE-1:0]    win_mask;
  logic [DATA_SIZE-1:0]    win_wdata;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      ({p1_req_valid, p0_req_valid}),
    .grant_en   (grant),
    .winner     (winner),
    .last_grant (last_grant)
  );

  always_comb begin
    win_write   = p0_req_write;
    win_address = p0_req_address;
    win_mask    = p0_req_mask;
    win_wdata   = p0_req_wdata;
    if (winner) begin
      win_write   = p1_req_write;
      win_address = p1_req_address;
      win_mask    = p1_req_mask;
      win_wdata   = p1_req_wdata;
    end
  end

  assign cnt_inc = wait_cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Completion needs a busy phase first; a ready seen before that is the controller still idle.
  always_comb begin
    state_n  = state;
    grant    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (ram_controller_ready && (p0_req_valid || p1_req_valid)) begin
          grant   = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (seen_busy && ram_controller_ready) begin
          complete = 1'b1;
          state_n  = IDLE;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          timeout = 1'b1;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (ram_controller_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // last_grant already names the port that owns the transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q              <= 1'b0;
      ram_address       <= '0;
      ram_mask          <= '0;
      ram_write_value   <= '0;
      ram_write_trigger <= 1'b0;
      ram_read_trigger  <= 1'b0;
      req_ready_q       <= '0;
      resp_valid_q      <= '0;
      error_q           <= '0;
      rdata_q[0]        <= '0;
      rdata_q[1]        <= '0;
      seen_busy         <= 1'b0;
      wait_cnt          <= '0;
    end else begin
      req_ready_q       <= '0;
      resp_valid_q      <= '0;
      ram_write_trigger <= 1'b0;
      ram_read_trigger  <= 1'b0;
      if (grant) begin
        wr_q                <= win_write;
        ram_address         <= win_address;
        ram_mask            <= win_mask;
        ram_write_value     <= win_wdata;
        req_ready_q[winner] <= 1'b1;
        ram_write_trigger   <= win_write;
        ram_read_trigger    <= ~win_write;
      end
      if (state == ISSUE) begin
        seen_busy <= 1'b0;
        wait_cnt  <= '0;
      end
      if (state == WAIT) begin
        if (!ram_controller_ready) begin
          seen_busy <= 1'b1;
        end
        wait_cnt <= cnt_inc;
      end
      if (complete) begin
        resp_valid_q[last_grant] <= 1'b1;
        rdata_q[last_grant]      <= wr_q ? '0 : ram_read_value;
        error_q[last_grant]      <= (ram_error != 4'd0);
      end
      if (timeout) begin
        resp_valid_q[last_grant] <= 1'b1;
        rdata_q[last_grant]      <= '0;
        error_q[last_grant]      <= 1'b1;
      end
    end
  end

  assign p0_req_ready  = req_ready_q[PORT_INSTR];
  assign p1_req_ready  = req_ready_q[PORT_DATA];
  assign p0_resp_valid = resp_valid_q[PORT_INSTR];
  assign p1_resp_valid = resp_valid_q[PORT_DATA];
  assign p0_resp_rdata = rdata_q[PORT_INSTR];
  assign p1_resp_rdata = rdata_q[PORT_DATA];
  assign p0_resp_error = error_q[PORT_INSTR];
  assign p1_resp_error = error_q[PORT_DATA];
  assign dbg_state     = state;

endmodule
